alu_issue_ctrl: RTL and testbench

- Issue/decode controller on the driving side of the 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal register file, and drives alu_op, operands, shamt, carry-in and flag select.
- Consumes the ALU result, y_valid and flags to write back the destination register and update the 5-bit PSR.
- Sits between instruction fetch and the ALU in the datapath.

---
 rtl/alu_issue_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/decode controller for a 16-bit ALU; owns the register file and PSR writeback.
// Optional `ILLEGAL_TRAP_EN: an illegal instruction raises sticky illegal_trap and parks in WAIT until reset.
module alu_issue_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 16
) (
   input  logic             clk,
   input  logic             rst,
`ifdef ILLEGAL_TRAP_EN
   output logic             illegal_trap,
`endif
   input  logic             instr_valid,
   input  logic [15:0]      instr,
   output logic             instr_ready,
   input  logic             wake,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [4:0]       alu_op,
   output logic [4:0]       alu_shamt,
   output logic             alu_psr_c,
   output logic             alu_flags_en,
   output logic [4:0]       alu_flags_sel,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_y_valid,
   input  logic [4:0]       alu_flags_out,
   output logic [4:0]       psr_out,
   output logic             busy,
   input  logic [3:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam int unsigned IMM_W = 8;
   localparam logic [4:0] OP_NOP  = 5'd29;
   localparam logic [4:0] SEL_ADD = 5'b11001;
   localparam logic [4:0] SEL_SUB = 5'b01001;
   localparam logic [4:0] SEL_CMP = 5'b00111;
   localparam logic [4:0] SEL_LOG = 5'b00101;
`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;
   typedef enum logic [1:0] {B_REG, B_SEXT, B_ZEXT, B_ZERO} bsel_t;
   typedef enum logic [1:0] {SH_NONE, SH_IMM, SH_REG} shsel_t;

   typedef struct packed {
      logic [4:0] op;
      logic [4:0] sel;
      logic       wr;
      logic       is_wait;
      logic       ill;
      bsel_t      bsel;
      shsel_t     shsel;
   } ctrl_t;

   // Maps op/ext to ALU opcode, flag mask, writeback and operand-B/shift source.
   function automatic ctrl_t decode(input logic [15:0] w);
      ctrl_t c;
      c = '{op: OP_NOP, sel: 5'b0, wr: 1'b1, is_wait: 1'b0, ill: 1'b0,
            bsel: B_REG, shsel: SH_NONE};
      case (w[15:12])
         4'h0: begin
            case (w[7:4])
               4'h5: begin c.op = 5'd0;  c.sel = SEL_ADD; end
               4'h6:       c.op = 5'd2;
               4'h7: begin c.op = 5'd4;  c.sel = SEL_ADD; end
               4'h9: begin c.op = 5'd8;  c.sel = SEL_SUB; end
               4'hB: begin c.op = 5'd10; c.sel = SEL_CMP; c.wr = 1'b0; end
               4'h1: begin c.op = 5'd14; c.sel = SEL_LOG; end
               4'h2: begin c.op = 5'd16; c.sel = SEL_LOG; end
               4'h3: begin c.op = 5'd18; c.sel = SEL_LOG; end
               4'hD:       c.op = 5'd27;
               4'hE: begin c.op = 5'd20; c.sel = SEL_LOG; end
               4'h0:       c.wr = 1'b0;
               4'hF: begin c.op = 5'd30; c.wr = 1'b0; c.is_wait = 1'b1; end
               default: begin c.wr = 1'b0; c.ill = 1'b1; end
            endcase
         end
         4'h5: begin c.op = 5'd1;  c.sel = SEL_ADD; c.bsel = B_SEXT; end
         4'h6: begin c.op = 5'd3;  c.bsel = B_ZEXT; end
         4'h7: begin c.op = 5'd5;  c.sel = SEL_ADD; c.bsel = B_SEXT; end
         4'h9: begin c.op = 5'd9;  c.sel = SEL_SUB; c.bsel = B_SEXT; end
         4'hB: begin c.op = 5'd11; c.sel = SEL_CMP; c.bsel = B_SEXT; c.wr = 1'b0; end
         4'h1: begin c.op = 5'd15; c.sel = SEL_LOG; c.bsel = B_ZEXT; end
         4'h2: begin c.op = 5'd17; c.sel = SEL_LOG; c.bsel = B_ZEXT; end
         4'h3: begin c.op = 5'd19; c.sel = SEL_LOG; c.bsel = B_ZEXT; end
         4'hD: begin c.op = 5'd27; c.bsel = B_ZEXT; end
         4'hF: begin c.op = 5'd28; c.bsel = B_ZEXT; end
         4'h8: begin
            case (w[7:4])
               4'h0: begin c.op = 5'd22; c.bsel = B_ZERO; c.shsel = SH_IMM; end
               4'h1: begin c.op = 5'd24; c.bsel = B_ZERO; c.shsel = SH_IMM; end
               4'h4: begin c.op = 5'd21; c.shsel = SH_REG; end
               4'h5: begin c.op = 5'd23; c.shsel = SH_REG; end
               4'h6: begin c.op = 5'd25; c.shsel = SH_REG; end
               default: begin c.wr = 1'b0; c.ill = 1'b1; end
            endcase
         end
         default: begin c.wr = 1'b0; c.ill = 1'b1; end
      endcase
      return c;
   endfunction

   state_t           state;
   logic [WIDTH-1:0] regs [NREGS];
   logic [4:0]       psr;
   logic [3:0]       ex_rd;
   logic             ex_wr;
   logic             ex_wait;
   logic             ex_ill;
   logic             trap_q;

   ctrl_t            dc;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] b_val;
   logic [4:0]       shamt_val;

   // Operand selection for the word on the instr port, captured on accept.
   always_comb begin
      dc        = decode(instr);
      rs_val    = regs[instr[3:0]];
      b_val     = rs_val;
      shamt_val = 5'd0;
      case (dc.bsel)
         B_SEXT:  b_val = {{(WIDTH-IMM_W){instr[7]}}, instr[7:0]};
         B_ZEXT:  b_val = WIDTH'(instr[7:0]);
         B_ZERO:  b_val = '0;
         default: b_val = rs_val;
      endcase
      case (dc.shsel)
         SH_IMM:  shamt_val = {1'b0, instr[3:0]};
         SH_REG:  shamt_val = rs_val[4:0];
         default: shamt_val = 5'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         psr           <= 5'd0;
         ex_rd         <= 4'd0;
         ex_wr         <= 1'b0;
         ex_wait       <= 1'b0;
         ex_ill        <= 1'b0;
         trap_q        <= 1'b0;
         instr_ready   <= 1'b1;
         busy          <= 1'b0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_op        <= OP_NOP;
         alu_shamt     <= 5'd0;
         alu_flags_en  <= 1'b0;
         alu_flags_sel <= 5'd0;
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  state         <= S_EXEC;
                  instr_ready   <= 1'b0;
                  busy          <= 1'b1;
                  ex_rd         <= instr[11:8];
                  ex_wr         <= dc.wr;
                  ex_wait       <= dc.is_wait;
                  ex_ill        <= dc.ill;
                  alu_a         <= regs[instr[11:8]];
                  alu_b         <= b_val;
                  alu_op        <= dc.op;
                  alu_shamt     <= shamt_val;
                  alu_flags_sel <= dc.sel;
                  alu_flags_en  <= |dc.sel;
               end
            end
            S_EXEC: begin
               if (ex_wr && alu_y_valid) regs[ex_rd] <= alu_y;
               if (alu_flags_en)
                  psr <= (psr & ~alu_flags_sel) | (alu_flags_out & alu_flags_sel);
               alu_a         <= '0;
               alu_b         <= '0;
               alu_op        <= OP_NOP;
               alu_shamt     <= 5'd0;
               alu_flags_en  <= 1'b0;
               alu_flags_sel <= 5'd0;
               // A trapped illegal parks in WAIT with wake masked by trap_q.
               if (ex_wait || (TRAP_EN && ex_ill)) begin
                  state  <= S_WAIT;
                  trap_q <= TRAP_EN && ex_ill;
               end else begin
                  state       <= S_IDLE;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            S_WAIT: begin
               if (wake && !trap_q) begin
                  state       <= S_IDLE;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign alu_psr_c = psr[4];
   assign psr_out   = psr;
   assign dbg_data  = regs[dbg_addr];
`ifdef ILLEGAL_TRAP_EN
   assign illegal_trap = trap_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed + randomized issue stream checked against a table-driven model of the decode rules.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP_BUILD = 1'b1;
`else
   localparam bit TRAP_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic        wake;
   logic [15:0] alu_a, alu_b, alu_y, dbg_data;
   logic [4:0]  alu_op, alu_shamt, alu_flags_sel, alu_flags_out, psr_out;
   logic        alu_psr_c, alu_flags_en, alu_y_valid, busy;
   logic [3:0]  dbg_addr;
`ifdef ILLEGAL_TRAP_EN
   logic        illegal_trap;
`endif

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst),
`ifdef ILLEGAL_TRAP_EN
      .illegal_trap(illegal_trap),
`endif
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready), .wake(wake),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
      .alu_psr_c(alu_psr_c), .alu_flags_en(alu_flags_en), .alu_flags_sel(alu_flags_sel),
      .alu_y(alu_y), .alu_y_valid(alu_y_valid), .alu_flags_out(alu_flags_out),
      .psr_out(psr_out), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   int n_chk = 0;
   int n_bad = 0;

   // Reference state and decode tables (-1 = illegal).
   logic [15:0] m_r [16];
   logic [4:0]  m_psr;
   int r_op [16] = '{29, 14, 16, 18, -1, 0, 2, 4, -1, 8, -1, 10, -1, 27, 20, 30};
   int i_op [16] = '{-1, 15, 17, 19, -1, 1, 3, 5, -1, 9, -1, 11, -1, 27, -1, 28};
   int s_op [16] = '{22, 24, -1, -1, 21, 23, 25, -1, -1, -1, -1, -1, -1, -1, -1, -1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_aop(input logic [15:0] w);
      if (w[15:12] == 4'h0) return r_op[w[7:4]];
      if (w[15:12] == 4'h8) return s_op[w[7:4]];
      return i_op[w[15:12]];
   endfunction

   function automatic logic [4:0] exp_sel(input int aop);
      if (aop inside {0, 1, 4, 5}) return 5'b11001;
      if (aop inside {8, 9})       return 5'b01001;
      if (aop inside {10, 11})     return 5'b00111;
      if (aop >= 14 && aop <= 20)  return 5'b00101;
      return 5'b00000;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
      m_psr = 5'd0;
   endtask

   task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
      dbg_addr = a;
      #1;
      v = dbg_data;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && instr_ready !== 1'b1; i++) begin
         @(posedge clk);
         #1;
      end
      chk("ready_wait", 32'(instr_ready), 32'd1);
   endtask

   task automatic issue(input logic [15:0] w, input logic [15:0] y, input logic yv,
                        input logic [4:0] fl, input logic wake_exec);
      int          aop;
      bit          legal, wr, is_wait, trap;
      logic [3:0]  rd, rs;
      logic [4:0]  sel, esh;
      logic [15:0] eb, rv;
      rd      = w[11:8];
      rs      = w[3:0];
      aop     = exp_aop(w);
      legal   = (aop >= 0);
      sel     = legal ? exp_sel(aop) : 5'd0;
      wr      = legal && !(aop inside {10, 11, 29, 30});
      is_wait = legal && (aop == 30);
      trap    = !legal && TRAP_BUILD;
      if (!legal || w[15:12] == 4'h0) eb = m_r[rs];
      else if (w[15:12] == 4'h8) eb = (aop inside {22, 24}) ? 16'h0 : m_r[rs];
      else if (aop inside {1, 5, 9, 11}) eb = {{8{w[7]}}, w[7:0]};
      else eb = {8'h00, w[7:0]};
      if (aop inside {22, 24}) esh = {1'b0, rs};
      else if (aop inside {21, 23, 25}) esh = m_r[rs][4:0];
      else esh = 5'd0;

      wait_ready();
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      chk("exec_op", 32'(alu_op), legal ? 32'(aop) : 32'd29);
      chk("exec_a", 32'(alu_a), 32'(m_r[rd]));
      chk("exec_b", 32'(alu_b), 32'(eb));
      chk("exec_shamt", 32'(alu_shamt), 32'(esh));
      chk("exec_sel", 32'(alu_flags_sel), 32'(sel));
      chk("exec_en", 32'(alu_flags_en), 32'(sel != 5'd0));
      chk("exec_psr_c", 32'(alu_psr_c), 32'(m_psr[4]));
      chk("exec_ready", 32'(instr_ready), 32'd0);
      alu_y = y;
      alu_y_valid = yv;
      alu_flags_out = fl;
      wake = wake_exec;
      @(posedge clk);
      #1;
      wake = 1'b0;
      alu_y_valid = 1'b0;
      alu_y = 16'($urandom);
      alu_flags_out = 5'($urandom);
      if (wr && yv) m_r[rd] = y;
      if (sel != 5'd0) m_psr = (m_psr & ~sel) | (fl & sel);
      chk("post_op", 32'(alu_op), 32'd29);
      chk("post_en", 32'(alu_flags_en), 32'd0);
      chk("post_psr", 32'(psr_out), 32'(m_psr));
      chk("post_busy", 32'(busy), 32'(is_wait || trap));
      chk("post_ready", 32'(instr_ready), 32'(!(is_wait || trap)));
      read_reg(rd, rv);
      chk("post_rd", 32'(rv), 32'(m_r[rd]));
      if (is_wait) begin
         // Offer an instruction throughout WAIT; it must not be taken.
         instr_valid = 1'b1;
         instr = 16'h5FFF;
         for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_ready", 32'(instr_ready), 32'd0);
         end
         instr_valid = 1'b0;
         wake = 1'b1;
         @(posedge clk);
         #1;
         wake = 1'b0;
         chk("wake_ready", 32'(instr_ready), 32'd1);
         chk("wake_busy", 32'(busy), 32'd0);
         read_reg(4'hF, rv);
         chk("wait_no_write", 32'(rv), 32'(m_r[15]));
      end
      if (trap) begin
`ifdef ILLEGAL_TRAP_EN
         chk("trap_set", 32'(illegal_trap), 32'd1);
`endif
         wake = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("trap_hold", 32'(busy), 32'd1);
         end
         wake = 1'b0;
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         model_reset();
`ifdef ILLEGAL_TRAP_EN
         chk("trap_clear", 32'(illegal_trap), 32'd0);
`endif
         chk("trap_rst_ready", 32'(instr_ready), 32'd1);
      end
   endtask

   task automatic reset_mid_exec(input logic [15:0] w);
      logic [15:0] rv;
      wait_ready();
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      chk("rme_busy", 32'(busy), 32'd1);
      alu_y = 16'h0005;
      alu_y_valid = 1'b1;
      alu_flags_out = 5'b11111;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      alu_y_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      read_reg(w[11:8], rv);
      chk("rme_reg", 32'(rv), 32'd0);
      chk("rme_psr", 32'(psr_out), 32'd0);
      chk("rme_op", 32'(alu_op), 32'd29);
      chk("rme_ready", 32'(instr_ready), 32'd1);
      chk("rme_busy_low", 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w, rv;
      rst = 1'b1;
      instr_valid = 1'b0;
      instr = 16'h0;
      wake = 1'b0;
      alu_y = 16'h0;
      alu_y_valid = 1'b0;
      alu_flags_out = 5'd0;
      dbg_addr = 4'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_op", 32'(alu_op), 32'd29);
      chk("rst_a", 32'(alu_a), 32'd0);
      chk("rst_b", 32'(alu_b), 32'd0);
      chk("rst_shamt", 32'(alu_shamt), 32'd0);
      chk("rst_en", 32'(alu_flags_en), 32'd0);
      chk("rst_sel", 32'(alu_flags_sel), 32'd0);
      chk("rst_psr", 32'(psr_out), 32'd0);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);

      issue(16'h5107, 16'h0007, 1'b1, 5'b11111, 1'b0);
      reset_mid_exec(16'h5105);

      issue(16'h52FF, 16'hFFFF, 1'b1, 5'b00001, 1'b0);
      chk("addi_psr", 32'(psr_out), 32'h01);
      read_reg(4'h2, rv);
      chk("addi_r2", 32'(rv), 32'hFFFF);

      issue(16'hD380, 16'h0080, 1'b1, 5'b00000, 1'b0);
      issue(16'h0393, 16'h0000, 1'b1, 5'b00000, 1'b0);
      read_reg(4'h3, rv);
      chk("sub_r3", 32'(rv), 32'h0);

      issue(16'h5501, 16'h0002, 1'b1, 5'b10000, 1'b0);
      chk("psr_pre_cmpi", 32'(psr_out), 32'h10);
      issue(16'hB403, 16'hDEAD, 1'b1, 5'b00110, 1'b0);
      chk("cmpi_psr", 32'(psr_out), 32'h16);
      read_reg(4'h4, rv);
      chk("cmpi_r4", 32'(rv), 32'h0);

      issue(16'h00F0, 16'h1111, 1'b1, 5'b11111, 1'b1);
      issue(16'h0C00, 16'h2222, 1'b1, 5'b11111, 1'b0);
      issue(16'h8123, 16'h0040, 1'b1, 5'b11111, 1'b0);
      issue(16'h0A4B, 16'h3333, 1'b1, 5'b00000, 1'b0);
      issue(16'h8564, 16'h0001, 1'b0, 5'b00000, 1'b0);
      issue(16'hC000, 16'h1234, 1'b1, 5'b11111, 1'b0);

      for (int n = 0; n < 300; n++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 3) == 0) w[15:12] = 4'h0;
         if ($urandom_range(0, 5) == 0) w[15:12] = 4'h8;
         while (TRAP_BUILD && exp_aop(w) < 0) w = 16'($urandom);
         issue(w, 16'($urandom), ($urandom_range(0, 3) != 0), 5'($urandom),
               ($urandom_range(0, 3) == 0));
      end

      for (int i = 0; i < 16; i++) begin
         read_reg(4'(i), rv);
         chk("final_reg", 32'(rv), 32'(m_r[i]));
      end
      chk("final_psr", 32'(psr_out), 32'(m_psr));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
